mult_div_unit: RTL

Iterative 16-bit multiply/divide unit that sits directly upstream of the register file. It takes the accumulator value (`res_val`) and a selected register value (`reg_val`) as operands and computes the result over 16 cycles. Its result feeds the register file's `write_data` input through the ALU result mux. It replaces a single-cycle combinational multiplier/divider, which cannot close timing.

---
 rtl/mult_div_unit_pkg.sv | 19 +
 rtl/mult_div_unit_if.sv | 28 ++
 rtl/mult_div_unit.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit. The opcode
// encoding is also used by the instruction decoder and the ALU result mux.
package mult_div_unit_pkg;

    localparam int MDU_WIDTH = 16;

    typedef enum logic [1:0] {
        OP_MULLO = 2'd0,
        OP_MULHI = 2'd1,
        OP_DIV   = 2'd2,
        OP_REM   = 2'd3
    } mdu_op_e;

    // DIV and REM share the restoring-division datapath.
    function automatic logic is_div_op(input mdu_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the issuing control logic (master) and
// the multiply/divide unit (slave).
interface mult_div_unit_if
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
);

    logic             start;
    mdu_op_e          op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             div0;

    modport master (
        output start, op, a, b,
        input  busy, done, result, div0
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, div0
    );

endinterface

// File: rtl/mult_div_unit.sv
// Iterative unsigned multiply/divide unit. One shared 2*WIDTH register holds
// {high, low} of the product while multiplying and {remainder, quotient}
// while dividing. Each operation takes WIDTH iterations after the start edge.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
)
(
    input  logic          clk,
    input  logic          reset,
    mult_div_unit_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    mdu_op_e            op_q, op_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               done_q, done_d;
    logic               div0_q, div0_d;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_iter;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     trial;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_iter;

    // One iteration of both datapaths, computed from the current register.
    always_comb begin
        // Shift-add: add the multiplicand when the multiplier LSB is set,
        // then shift the whole {carry, high, low} right by one.
        mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                 + (prod_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        mul_iter = {mul_sum, prod_q[WIDTH-1:1]};

        // Restoring division: remainder < divisor always holds, so the
        // shifted remainder is below 2*divisor and trial[WIDTH] is a clean
        // borrow flag. With a zero divisor the subtraction always succeeds,
        // giving an all-ones quotient and the dividend as remainder.
        rem_shift = prod_q[2*WIDTH-1:WIDTH-1];
        trial     = rem_shift - {1'b0, b_q};
        div_ge    = ~trial[WIDTH];
        div_iter  = {(div_ge ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0]),
                     prod_q[WIDTH-2:0], div_ge};
    end

    // Control FSM next-state and datapath/output next values.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        done_d   = 1'b0;
        div0_d   = div0_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    op_d    = bus.op;
                    // Low half seeds the multiplier or the dividend bits.
                    prod_d  = is_div_op(bus.op) ? {{WIDTH{1'b0}}, bus.a}
                                                : {{WIDTH{1'b0}}, bus.b};
                end
            end

            S_RUN: begin
                prod_d = is_div_op(op_q) ? div_iter : mul_iter;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    div0_d  = is_div_op(op_q) && (b_q == '0);
                    case (op_q)
                        OP_MULLO: result_d = prod_d[WIDTH-1:0];
                        OP_MULHI: result_d = prod_d[2*WIDTH-1:WIDTH];
                        OP_DIV:   result_d = prod_d[WIDTH-1:0];
                        OP_REM:   result_d = prod_d[2*WIDTH-1:WIDTH];
                        default:  result_d = prod_d[WIDTH-1:0];
                    endcase
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    // NOTE: the datapath registers are reset as well, because the outputs
    // must read as zero immediately on reset; there is no memory array here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            prod_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_MULLO;
            result_q <= '0;
            done_q   <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            done_q   <= done_d;
            div0_q   <= div0_d;
        end
    end

    assign bus.busy   = (state_q == S_RUN);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.div0   = div0_q;

endmodule
